// File: rtl/mux_source_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux_source_arbiter
// Description : Round-robin arbiter for keypad (A) / preset (B) sources on the
//               shared 2:1 MUX feeding the timer loader, with valid/ack output.
//               Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_source_arbiter #(
  parameter int DATA_W      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              ack,
  output logic              sel,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              timeout,
  output logic [7:0]        done_cnt
);

  // Grant states are one-hot so gnt_a/gnt_b come straight off state flops.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GNT_A = 2'b01,
    ST_GNT_B = 2'b10
  } state_e;

  state_e              state_q, state_d;
  logic                last_b_q, last_b_d;
  logic                sel_q, sel_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [7:0]          done_cnt_q, done_cnt_d;
  logic                cur_req;
  logic [DATA_W-1:0]   cur_data;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYC[7:0];
  logic       timeout_q, timeout_d;
  logic [7:0] wait_q, wait_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign cur_req  = (state_q == ST_GNT_B) ? req_b  : req_a;
  assign cur_data = (state_q == ST_GNT_B) ? data_b : data_a;

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    sel_d      = sel_q;
    out_data_d = out_data_q;
    done_cnt_d = done_cnt_q;
`ifdef ARB_TIMEOUT_EN
    timeout_d  = 1'b0;
    wait_d     = 8'd0;
`endif
    case (state_q)
      ST_IDLE: begin
        // On contention the side opposite the last winner takes the grant.
        if (req_a && (!req_b || last_b_q)) begin
          state_d    = ST_GNT_A;
          sel_d      = 1'b0;
          out_data_d = data_a;
        end else if (req_b) begin
          state_d    = ST_GNT_B;
          sel_d      = 1'b1;
          out_data_d = data_b;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        if (ack) begin
          state_d    = ST_IDLE;
          last_b_d   = (state_q == ST_GNT_B);
          done_cnt_d = done_cnt_q + 8'd1;
        end else if (!cur_req) begin
          state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (wait_q == TIMEOUT_LIM) begin
          state_d   = ST_IDLE;
          last_b_d  = (state_q == ST_GNT_B);
          timeout_d = 1'b1;
`endif
        end else begin
          out_data_d = cur_data;
`ifdef ARB_TIMEOUT_EN
          wait_d     = wait_q + 8'd1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      last_b_q   <= 1'b1;
      sel_q      <= 1'b0;
      out_data_q <= '0;
      done_cnt_q <= 8'd0;
`ifdef ARB_TIMEOUT_EN
      timeout_q  <= 1'b0;
      wait_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      sel_q      <= sel_d;
      out_data_q <= out_data_d;
      done_cnt_q <= done_cnt_d;
`ifdef ARB_TIMEOUT_EN
      timeout_q  <= timeout_d;
      wait_q     <= wait_d;
`endif
    end
  end

  assign gnt_a     = state_q[0];
  assign gnt_b     = state_q[1];
  assign out_valid = |state_q;
  assign sel       = sel_q;
  assign out_data  = out_data_q;
  assign done_cnt  = done_cnt_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule
`default_nettype wire
